// File: rtl/lcd1602_responder_if.sv
// rtl/lcd1602_responder_if.sv - LCD1602 parallel bus plus side read port and status
interface lcd1602_responder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       disp_on;
  logic       cursor_on;
  logic       blink_on;
  logic       shift_on;
  logic       overrun;

  modport master (
    output lcd_rs, lcd_rw, lcd_en, lcd_data_in, rd_addr,
    input  lcd_data_out, lcd_data_oe, rd_data, busy,
           disp_on, cursor_on, blink_on, shift_on, overrun
  );

  modport slave (
    input  lcd_rs, lcd_rw, lcd_en, lcd_data_in, rd_addr,
    output lcd_data_out, lcd_data_oe, rd_data, busy,
           disp_on, cursor_on, blink_on, shift_on, overrun
  );
endinterface

// File: rtl/lcd1602_responder.sv
// rtl/lcd1602_responder.sv - HD44780-style display end: DDRAM mirror, AC, busy flag, bus read-back
module lcd1602_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd1602_responder_if.slave bus
);
  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  logic [1:0]  rs_sync, rw_sync, en_sync;
  logic [7:0]  d_meta, d_sync;
  logic        en_last;
  logic        rs_s, rw_s, en_s, en_fall;
  logic        wr_evt, rd_evt, accept, clear_go;
  logic [7:0]  ram [32];
  logic [6:0]  ac;
  logic        inc_mode, shift_mode, cg_mode;
  logic [2:0]  dcb;
  logic [31:0] busy_cnt;
  logic        busy_i, overrun_q, oe_q;
  logic [7:0]  dout_q;
  state_t      state, state_nxt;
  logic [4:0]  fill_idx;
  logic        fill_we, fill_last;
  logic        ac_visible, ram_we;
  logic [4:0]  ac_idx;
  logic [7:0]  rd_cell;

  // Two-line address space: 0x00-0x27 then 0x40-0x67, wrapping end to end.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      case (a)
        7'h27:   return 7'h40;
        7'h67:   return 7'h00;
        default: return a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h00:   return 7'h67;
        7'h40:   return 7'h27;
        default: return a - 7'd1;
      endcase
    end
  endfunction

  function automatic logic [6:0] ac_clamp(input logic [6:0] a);
    return ((a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67))) ? a : 7'h00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_sync <= '0;
      rw_sync <= '0;
      en_sync <= '0;
      d_meta  <= '0;
      d_sync  <= '0;
      en_last <= 1'b0;
    end else begin
      rs_sync <= {rs_sync[0], bus.lcd_rs};
      rw_sync <= {rw_sync[0], bus.lcd_rw};
      en_sync <= {en_sync[0], bus.lcd_en};
      d_meta  <= bus.lcd_data_in;
      d_sync  <= d_meta;
      en_last <= en_sync[1];
    end
  end

  assign rs_s       = rs_sync[1];
  assign rw_s       = rw_sync[1];
  assign en_s       = en_sync[1];
  assign en_fall    = en_last & ~en_s;
  assign wr_evt     = en_fall & ~rw_s;
  assign rd_evt     = en_fall & rw_s;
  assign busy_i     = (busy_cnt != '0);
  assign accept     = wr_evt & ~busy_i;
  assign clear_go   = accept & ~rs_s & (d_sync == 8'h01);
  assign ac_visible = (ac[5:4] == 2'b00);
  assign ac_idx     = {ac[6], ac[3:0]};
  assign rd_cell    = cg_mode ? 8'h00 : (ac_visible ? ram[ac_idx] : 8'h20);
  assign ram_we     = accept & rs_s & ~cg_mode & ac_visible;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac         <= 7'h00;
      inc_mode   <= 1'b1;
      shift_mode <= 1'b0;
      cg_mode    <= 1'b0;
      dcb        <= 3'b000;
    end else if (accept && rs_s) begin
      if (!cg_mode) ac <= ac_step(ac, inc_mode);
    end else if (accept) begin
      // Instruction class is chosen by the highest set bit.
      casez (d_sync)
        8'b1???????: begin
          ac      <= ac_clamp(d_sync[6:0]);
          cg_mode <= 1'b0;
        end
        8'b01??????: cg_mode <= 1'b1;
        8'b001?????: ;
        8'b0001????: if (!d_sync[3]) ac <= ac_step(ac, d_sync[2]);
        8'b00001???: dcb <= d_sync[2:0];
        8'b000001??: begin
          inc_mode   <= d_sync[1];
          shift_mode <= d_sync[0];
        end
        8'b0000001?: ac <= 7'h00;
        8'b00000001: begin
          ac       <= 7'h00;
          inc_mode <= 1'b1;
        end
        default: ;
      endcase
    end else if (rd_evt && rs_s && !cg_mode) begin
      ac <= ac_step(ac, inc_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (clear_go)    busy_cnt <= 32'(CLEAR_CYCLES);
      else if (accept) busy_cnt <= 32'(BUSY_CYCLES);
      else if (busy_i) busy_cnt <= busy_cnt - 32'd1;
      if (wr_evt && busy_i) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      oe_q   <= en_s & rw_s;
      dout_q <= (en_s && rw_s) ? (rs_s ? rd_cell : {busy_i, ac}) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (clear_go) state_nxt = ST_FILL;
      ST_FILL: if (fill_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_we   = (state == ST_FILL);
    fill_last = fill_we && (fill_idx == 5'd31);
  end

  // fill_idx wraps 31 -> 0, so it is back at 0 whenever a fill starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fill_idx <= 5'd0;
    else if (fill_we) fill_idx <= fill_idx + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'h20;
    end else if (fill_we) begin
      ram[fill_idx] <= 8'h20;
    end else if (ram_we) begin
      ram[ac_idx] <= d_sync;
    end
  end

  assign bus.rd_data      = ram[bus.rd_addr];
  assign bus.lcd_data_out = dout_q;
  assign bus.lcd_data_oe  = oe_q;
  assign bus.busy         = busy_i;
  assign bus.disp_on      = dcb[2];
  assign bus.cursor_on    = dcb[1];
  assign bus.blink_on     = dcb[0];
  assign bus.shift_on     = shift_mode;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_lcd1602_responder.sv
// tb/tb_lcd1602_responder.sv - randomized bench for lcd1602_responder against a line/column display model
module tb_lcd1602_responder;
  localparam int BUSY_N  = 40;
  localparam int CLEAR_N = 300;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   run_len  = 0;
  int   last_run = 0;

  lcd1602_responder_if bus ();

  lcd1602_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy === 1'b1) run_len++;
    else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  end

  logic [7:0] m_mem [32];
  logic [6:0] m_ac;
  logic       m_id, m_s, m_cg, m_ovr;
  logic [2:0] m_dcb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The model keeps AC as a position 0..79 along the two 40-column lines.
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
    int p;
    p = (a[6] ? 40 : 0) + int'(a[5:0]);
    p = inc ? (p + 1) % 80 : (p + 79) % 80;
    return (p >= 40) ? 7'(64 + p - 40) : 7'(p);
  endfunction

  function automatic logic m_vis(input logic [6:0] a);
    return int'(a[5:0]) < 16;
  endfunction

  function automatic int m_idx(input logic [6:0] a);
    return (a[6] ? 16 : 0) + int'(a[3:0]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1; m_s = 0; m_cg = 0; m_ovr = 0; m_dcb = 0;
  endtask

  task automatic m_write(input logic rs, input logic [7:0] d);
    int h;
    if (rs) begin
      if (!m_cg) begin
        if (m_vis(m_ac)) m_mem[m_idx(m_ac)] = d;
        m_ac = m_step(m_ac, m_id);
      end
      return;
    end
    h = -1;
    for (int i = 7; i >= 0; i--) if (d[i] && h < 0) h = i;
    case (h)
      7: begin m_ac = (int'(d[5:0]) < 40) ? d[6:0] : 7'h00; m_cg = 0; end
      6: m_cg = 1;
      4: if (!d[3]) m_ac = m_step(m_ac, d[2]);
      3: m_dcb = d[2:0];
      2: begin m_id = d[1]; m_s = d[0]; end
      1: m_ac = 0;
      0: begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_id = 1;
      end
      default: ;
    endcase
  endtask

  task automatic m_read_data(output logic [7:0] v);
    if (m_cg) v = 8'h00;
    else begin
      v = m_vis(m_ac) ? m_mem[m_idx(m_ac)] : 8'h20;
      m_ac = m_step(m_ac, m_id);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data_in = d;
    repeat (2) @(negedge clk);
    bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] v, output logic oe);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_en = 1'b1;
    repeat (5) @(negedge clk);
    v = bus.lcd_data_out; oe = bus.lcd_data_oe;
    bus.lcd_en = 1'b0;
    repeat (5) @(negedge clk);
    check("oe_drop", bus.lcd_data_oe, 1'b0);
    bus.lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic check_cell(input string tag, input int a, input logic [7:0] exp);
    bus.rd_addr = 5'(a);
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic check_all_cells(input string tag);
    for (int i = 0; i < 32; i++) check_cell($sformatf("%s[%0d]", tag, i), i, m_mem[i]);
  endtask

  task automatic send_text(input logic [7:0] cmd, input string s);
    wait_idle(); bus_write(0, cmd); m_write(0, cmd);
    for (int i = 0; i < s.len(); i++) begin
      wait_idle(); bus_write(1, s[i]); m_write(1, s[i]);
    end
    wait_idle();
  endtask

  logic [7:0] v, exp_v, d;
  logic       oe;
  int         op;

  initial begin
    rst_n = 1'b0;
    bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_en = 0; bus.lcd_data_in = 0; bus.rd_addr = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_oe", bus.lcd_data_oe, 0);
    check("rst_dout", bus.lcd_data_out, 8'h00);
    check("rst_dcb", {bus.disp_on, bus.cursor_on, bus.blink_on}, 3'b000);
    check_all_cells("rst_cell");
    bus_read(0, v, oe);
    check("rst_status", v, 8'h00);
    check("rst_status_oe", oe, 1);

    send_text(8'h80, "Hello World*^_^*");
    check_cell("hello_00", 5'h00, 8'h48);
    check_cell("hello_0f", 5'h0F, 8'h2A);
    bus_read(0, v, oe);
    check("hello_status", v, 8'h10);
    check("busy_len", last_run, BUSY_N);

    send_text(8'hC0, "I am CrazyBingo!");
    check_cell("crazy_10", 5'h10, 8'h49);
    check_cell("crazy_1f", 5'h1F, 8'h21);
    bus_read(0, v, oe);
    check("crazy_status", v, 8'h50);

    send_text(8'hA7, "AB");
    check_cell("wrap_10", 5'h10, 8'h42);
    check_all_cells("wrap_cell");
    bus_read(0, v, oe);
    check("wrap_status", v, 8'h41);

    wait_idle(); bus_write(0, 8'h80); m_write(0, 8'h80); wait_idle();
    bus_read(1, v, oe);
    m_read_data(exp_v);
    check("dread_h", v, 8'h48);
    check("dread_oe", oe, 1);
    bus_read(0, v, oe);
    check("dread_ac", v, {1'b0, m_ac});

    wait_idle();
    bus_write(1, 8'h55); m_write(1, 8'h55);
    bus_write(1, 8'h66); m_ovr = 1;
    check("ovr_flag", bus.overrun, 1);
    check_cell("ovr_cell", m_idx(m_ac), m_mem[m_idx(m_ac)]);
    bus_read(0, v, oe);
    check("ovr_status", v, {1'b1, m_ac});

    for (int n = 0; n < 80; n++) begin
      wait_idle();
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        d = 8'($urandom_range(32, 126));
        bus_write(1, d); m_write(1, d);
      end else if (op <= 7) begin
        d = 8'($urandom_range(2, 255));
        bus_write(0, d); m_write(0, d);
      end else if (op == 8) begin
        bus_read(1, v, oe); m_read_data(exp_v);
        check("rnd_dread", v, exp_v);
      end else begin
        bus_read(0, v, oe);
        check("rnd_status", v, {1'b0, m_ac});
      end
      d = 8'($urandom_range(0, 31));
      check_cell("rnd_cell", int'(d), m_mem[d[4:0]]);
    end
    wait_idle();
    check_all_cells("rnd_end");
    check("rnd_dcb", {bus.disp_on, bus.cursor_on, bus.blink_on}, m_dcb);
    check("rnd_shift", bus.shift_on, m_s);
    check("rnd_overrun", bus.overrun, m_ovr);
    bus_read(0, v, oe);
    check("rnd_end_status", v, {1'b0, m_ac});

    send_text(8'h80, "Refill");
    bus_write(0, 8'h01); m_write(0, 8'h01);
    check("clr_busy", bus.busy, 1);
    repeat (38) @(negedge clk);
    check_all_cells("clr_cell");
    wait_idle(); @(negedge clk);
    check("clr_len", last_run, CLEAR_N);
    bus_read(0, v, oe);
    check("clr_status", v, 8'h00);

    send_text(8'h85, "Z");
    bus_write(0, 8'h01);
    repeat (5) @(negedge clk);
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_cells("mid_rst_cell");
    bus_read(0, v, oe);
    check("mid_rst_status", v, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- HD44780-compatible bus responder: the display end of the LCD1602 parallel interface that lcd1602_driver initiates.
- Samples RS/RW/EN/D[7:0] and decodes instructions and data writes into a 2x16 DDRAM mirror with address counter (AC) and busy flag.
- Answers busy-flag/address reads and data reads, and exposes a side read port so the team can check displayed text in simulation or mirror it to another display.

Parameters:
- BUSY_CYCLES, 2000, clk cycles busy after any accepted write except clear.
- CLEAR_CYCLES, 80000, clk cycles busy after Clear Display; must be >= 32.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- lcd_rs  in  1  H: data, L: instruction.
- lcd_rw  in  1  H: read, L: write.
- lcd_en  in  1  chip enable strobe.
- lcd_data_in  in  8  bus value driven by the initiator.
- lcd_data_out  out  8  read-back value.
- lcd_data_oe  out  1  high while the responder drives the bus.
- rd_addr  in  5  side port: {row, col[3:0]}.
- rd_data  out  8  DDRAM cell at rd_addr, combinational.
- busy  out  1  busy flag.
- disp_on / cursor_on / blink_on  out  1 each  display-control bits D/C/B.
- overrun  out  1  sticky: a write arrived while busy.

Behaviour:
- Reset: all 32 DDRAM cells = 0x20. AC = 0x00. I/D = 1, S = 0. D/C/B = 0. busy = 0. overrun = 0. lcd_data_oe = 0. lcd_data_out = 0x00. Mode = DDRAM. Reset mid-clear or mid-busy aborts immediately.
- Inputs pass through 2-flop synchronizers. The EN falling edge is detected on synchronized EN, so latch latency is 3 clk from the pin edge. RS/RW/D are taken from the synchronized copies at the detection cycle.
- Write (RW=0) on EN fall:
  - If busy=1: discard the write and set overrun.
  - Otherwise decode by the highest set bit of D:
    - 0x01 Clear: fill 0x20 into 32 cells, 1 cell/cycle. AC = 0, I/D = 1. busy for CLEAR_CYCLES.
    - 0x02-03 Home: AC = 0, DDRAM unchanged.
    - 0x04-07 Entry mode: I/D = D[1], S = D[0]. S is stored only; display shift is not modelled.
    - 0x08-0F Display control: D/C/B = D[2:0].
    - 0x10-1F Shift: if D[3]=0, move AC +1 when D[2]=1, else -1. If D[3]=1 (display shift), no change.
    - 0x20-3F Function set: accepted, no state change.
    - 0x40-7F Set CGRAM address: mode = CGRAM. Subsequent data writes and reads are discarded/return 0x00; AC unchanged.
    - 0x80-FF Set DDRAM address: AC = D[6:0], mode = DDRAM.
  - Data write (RS=1) in DDRAM mode: if AC is in 0x00-0x0F (row 0) or 0x40-0x4F (row 1), store D in that cell; other AC values store nothing. AC then steps per I/D.
- Busy: every accepted write except Clear sets busy for BUSY_CYCLES, starting the cycle after decode.
- AC stepping follows 2-line wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - AC is never outside 0x00-0x27 or 0x40-0x67. A Set-address value outside these ranges is clamped to 0x00.
- Read (RW=1): while synchronized EN=1, lcd_data_oe = 1.
  - RS=0: lcd_data_out = {busy, AC}.
  - RS=1: lcd_data_out = cell at AC (0x20 if AC is not visible).
  - On EN fall after an RS=1 read, AC steps per I/D. Reads are allowed while busy and never set overrun.
- lcd_data_oe drops the cycle after EN fall is detected. lcd_data_oe is never 1 when RW=0.
- Simultaneous events: rd_addr reads during a clear fill return the partially cleared contents.

Test Plan:
- Reset, then read status (RS=0, RW=1) -> lcd_data_out = 0x00, oe = 1 during EN high; rd_data = 0x20 at every rd_addr.
- Write 0x80, then "Hello World*^_^*" as 16 data writes, each after busy drops -> rd_addr 0x00 = 0x48, 0x0F = 0x2A; status read = 0x10.
- Write 0xC0, then "I am CrazyBingo!" -> rd_addr 0x10 = 0x49, 0x1F = 0x21; AC = 0x50.
- Write 0xA7, then 2 data bytes 0x41, 0x42 -> 0x41 not stored (AC 0x27 not visible); 0x42 lands at row 1 col 0 (rd_addr 0x10); AC = 0x41.
- Issue a data write 10 cycles after a previous write -> cell unchanged, overrun = 1, status read shows bit7 = 1.
- After filling text, write 0x01 -> busy = 1 for 80000 cycles; after 32 cycles all cells = 0x20; AC = 0. Assert rst_n low mid-clear -> busy = 0 immediately.
